golden_nonce_arbiter: RTL and testbench
=======================================

GOLDEN_NONCE_ARBITER -- requirements
Module: golden_nonce_arbiter

Interface
- REQ-001: Parameter NUM_CORES, default 2: number of mining cores feeding the arbiter; legal range 1..8.
- REQ-002: Parameter FIFO_DEPTH_LOG2, default 2: output FIFO holds 2**FIFO_DEPTH_LOG2 nonces.
- REQ-003: hash_clk  input  1: single clock; all logic on its rising edge.
- REQ-004: reset  input  1: synchronous, active-high reset.
- REQ-005: rx_work_change  input  1: one-cycle pulse; new midstate/data loaded, stale results flushed.
- REQ-006: rx_is_golden_ticket  input  NUM_CORES: bit i is a one-cycle ticket pulse from core i.
- REQ-007: rx_golden_nonce  input  32*NUM_CORES: core i nonce in bits [32*i+31:32*i]; valid only with its ticket bit.
- REQ-008: tx_valid  output  1: FIFO non-empty; tx_nonce holds the head entry.
- REQ-009: tx_ready  input  1: consumer accepts the head when tx_valid and tx_ready are both high on an edge.
- REQ-010: tx_nonce  output  32: head-of-FIFO golden nonce (show-ahead).
- REQ-011: tx_overflow  output  1: sticky flag; at least one ticket has been lost.

Function
- REQ-012: Each core shall have a pending flag and a 32-bit nonce register; a ticket pulse on an edge shall set the flag and capture the nonce.
- REQ-013: A ticket arriving while that core's flag is set and not granted in the same cycle shall overwrite the captured nonce and set tx_overflow.
- REQ-014: If a core's flag is granted in the same cycle as a new ticket from that core, the new ticket shall set the flag with the new nonce, with no overflow.
- REQ-015: Each cycle with at least one pending flag and the FIFO not full, exactly one core shall be granted, round-robin, searching upward from (last granted index + 1) mod NUM_CORES.
- REQ-016: A grant shall clear that core's flag, push its nonce into the FIFO, and update the last-granted index.
- REQ-017: The grant shall be blocked whenever the FIFO is full, including when a pop occurs in the same cycle; pending flags hold their values meanwhile.
- REQ-018: Latency: ticket on edge E0 -> FIFO write on E1 -> tx_valid high after E1 (FIFO previously empty, no contention).
- REQ-019: Simultaneous push and pop on a non-full, non-empty FIFO shall both occur; entry count is unchanged.
- REQ-020: FIFO pointers shall wrap modulo 2**FIFO_DEPTH_LOG2; full and empty are distinguished by an extra pointer bit.
- REQ-021: rx_work_change shall clear all pending flags and empty the FIFO on that edge, and tickets on that same edge shall be discarded; tx_overflow and the last-granted index are retained.
- REQ-022: A pop while tx_valid is low shall be ignored.

Reset
- REQ-023: Reset shall clear all pending flags, FIFO pointers, tx_overflow, and the last-granted index (set to NUM_CORES-1 so core 0 is searched first).
- REQ-024: After reset, tx_valid shall be 0 and tx_nonce shall be 0.
- REQ-025: Reset shall take priority over rx_work_change, tickets, and pops on the same edge.

Configuration
- REQ-026: Macro GOLDEN_NONCE_DEDUP_EN: when defined, a granted nonce equal to the last nonce pushed since reset or rx_work_change shall clear the flag without pushing; when undefined, every grant shall push.

Structure
- REQ-027: Shared package mining_pkg shall hold the NONCE_WIDTH=32 constant and the nonce_t typedef used by the mining cores and this block.
- REQ-028: The FIFO shall be a sub-module nonce_fifo (parameterised depth, show-ahead, synchronous flush input).

Verification
- REQ-029: Core 0 ticket with 0x1234ABCD, tx_ready=1 -> tx_valid high 2 edges later with tx_nonce=0x1234ABCD, then low the next cycle.
- REQ-030: Cores 0 and 1 tick on the same edge (0xA, 0xB), last grant = 1 -> outputs in order 0xA then 0xB, tx_overflow=0.
- REQ-031: tx_ready=0, 6 tickets from core 0 spaced 2 cycles apart, FIFO depth 4 -> 4 entries held, fifth stays pending, sixth overwrites it, tx_overflow=1.
- REQ-032: FIFO holds 3 entries plus 1 pending; rx_work_change pulse together with a new ticket -> tx_valid=0 next cycle, no later output, tx_overflow unchanged.
- REQ-033: GOLDEN_NONCE_DEDUP_EN defined, core 1 reports 0x55 twice -> one output; after rx_work_change, 0x55 again -> output.
- REQ-034: Reset asserted mid-stream with FIFO full and tx_overflow=1 -> next cycle tx_valid=0, tx_nonce=0, tx_overflow=0.

Source files
------------

// File: rtl/mining_pkg.sv
// rtl/mining_pkg.sv - nonce width and type shared by the mining cores and the golden nonce arbiter
package mining_pkg;
    localparam int NONCE_WIDTH = 32;
    typedef logic [NONCE_WIDTH-1:0] nonce_t;
endpackage

// File: rtl/golden_nonce_arbiter_if.sv
// rtl/golden_nonce_arbiter_if.sv - show-ahead golden nonce output stream with sticky overflow flag
interface golden_nonce_arbiter_if;
    import mining_pkg::*;

    logic   tx_valid;
    logic   tx_ready;
    nonce_t tx_nonce;
    logic   tx_overflow;

    modport master (
        output tx_valid,
        output tx_nonce,
        output tx_overflow,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_nonce,
        input  tx_overflow,
        output tx_ready
    );
endinterface

// File: rtl/nonce_fifo.sv
// rtl/nonce_fifo.sv - show-ahead nonce FIFO with synchronous flush; head reads as zero when empty
module nonce_fifo
    import mining_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   push_i,
    input  nonce_t data_i,
    input  logic   pop_i,
    output nonce_t data_o,
    output logic   valid_o,
    output logic   full_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    nonce_t              mem_q [DEPTH];
    logic                empty;
    logic                do_push;
    logic                do_pop;

    // Extra MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty;
    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_i;
        end
    end
endmodule

// File: rtl/golden_nonce_arbiter.sv
// rtl/golden_nonce_arbiter.sv - round-robin collection of per-core golden tickets into a nonce FIFO
// Optional feature: GOLDEN_NONCE_DEDUP_EN drops a granted nonce equal to the last one pushed.
module golden_nonce_arbiter
    import mining_pkg::*;
#(
    parameter int NUM_CORES       = 2,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                             hash_clk,
    input  logic                             reset,
    input  logic                             rx_work_change,
    input  logic [NUM_CORES-1:0]             rx_is_golden_ticket,
    input  logic [NONCE_WIDTH*NUM_CORES-1:0] rx_golden_nonce,
    golden_nonce_arbiter_if.master           tx
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CORES - 1);

    logic [NUM_CORES-1:0] pend_q, pend_d;
    nonce_t               nonce_q [NUM_CORES];
    nonce_t               nonce_d [NUM_CORES];
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 ovf_q, ovf_d;

    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;
    nonce_t               grant_nonce;
    logic                 fifo_full;
    logic                 fifo_push;
    logic                 dup;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_CORES);
            if (!grant_vld && pend_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        // A full FIFO blocks even when the consumer pops on this edge.
        if (fifo_full || rx_work_change) grant_vld = 1'b0;
    end

    assign grant_nonce = nonce_q[grant_idx];

`ifdef GOLDEN_NONCE_DEDUP_EN
    nonce_t last_push_q;
    logic   last_push_vld_q;

    assign dup = last_push_vld_q && (grant_nonce == last_push_q);

    always_ff @(posedge hash_clk) begin
        if (reset || rx_work_change) begin
            last_push_q     <= '0;
            last_push_vld_q <= 1'b0;
        end else if (fifo_push) begin
            last_push_q     <= grant_nonce;
            last_push_vld_q <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign fifo_push = grant_vld && !dup;

    always_comb begin
        pend_d  = pend_q;
        nonce_d = nonce_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        if (rx_work_change) begin
            pend_d = '0;
        end else begin
            if (grant_vld) begin
                pend_d[grant_idx] = 1'b0;
                last_d            = grant_idx;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (rx_is_golden_ticket[i]) begin
                    if (pend_q[i] && !(grant_vld && (grant_idx == IDX_W'(i)))) ovf_d = 1'b1;
                    pend_d[i]  = 1'b1;
                    nonce_d[i] = rx_golden_nonce[NONCE_WIDTH*i +: NONCE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            pend_q <= '0;
            last_q <= LAST_RST;
            ovf_q  <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) nonce_q[i] <= '0;
        end else begin
            pend_q  <= pend_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            nonce_q <= nonce_d;
        end
    end

    nonce_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (hash_clk),
        .rst_i   (reset),
        .flush_i (rx_work_change),
        .push_i  (fifo_push),
        .data_i  (grant_nonce),
        .pop_i   (tx.tx_ready),
        .data_o  (tx.tx_nonce),
        .valid_o (tx.tx_valid),
        .full_o  (fifo_full)
    );

    assign tx.tx_overflow = ovf_q;
endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// tb/tb_golden_nonce_arbiter.sv - scoreboard bench for golden_nonce_arbiter with a queue-based reference model
module tb_golden_nonce_arbiter;
    localparam int NC    = 3;
    localparam int DLOG  = 2;
    localparam int DEPTH = 2 ** DLOG;
`ifdef GOLDEN_NONCE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              work = 1'b0;
    logic [NC-1:0]     tkt = '0;
    logic [32*NC-1:0]  nonce_bus = '0;
    logic              rdy = 1'b0;

    int checks = 0;
    int failures = 0;
    int outputs = 0;

    golden_nonce_arbiter_if gif ();
    assign gif.tx_ready = rdy;

    golden_nonce_arbiter #(
        .NUM_CORES       (NC),
        .FIFO_DEPTH_LOG2 (DLOG)
    ) dut (
        .hash_clk            (clk),
        .reset               (reset),
        .rx_work_change      (work),
        .rx_is_golden_ticket (tkt),
        .rx_golden_nonce     (nonce_bus),
        .tx                  (gif)
    );

    always #5 clk = ~clk;

    // Reference state: pending tickets per core, FIFO occupancy, expected output order.
    bit          m_pend [NC];
    logic [31:0] m_nonce [NC];
    int          m_last = NC - 1;
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_lp = '0;
    bit          m_lp_vld = 1'b0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int g;
        int c;
        bit had [NC];
        if (reset) begin
            for (int i = 0; i < NC; i++) m_pend[i] = 1'b0;
            m_cnt = 0; m_ovf = 1'b0; m_last = NC - 1; m_lp_vld = 1'b0;
            exp_q.delete();
        end else if (work) begin
            for (int i = 0; i < NC; i++) m_pend[i] = 1'b0;
            m_cnt = 0; m_lp_vld = 1'b0;
            exp_q.delete();
        end else begin
            for (int i = 0; i < NC; i++) had[i] = m_pend[i];
            g = -1;
            if (m_cnt < DEPTH) begin
                for (int k = 1; k <= NC; k++) begin
                    c = (m_last + k) % NC;
                    if (g < 0 && m_pend[c]) g = c;
                end
            end
            if (rdy && m_cnt > 0) m_cnt--;
            if (g >= 0) begin
                m_pend[g] = 1'b0;
                m_last = g;
                if (!(DEDUP && m_lp_vld && m_nonce[g] == m_lp)) begin
                    exp_q.push_back(m_nonce[g]);
                    m_cnt++;
                    m_lp = m_nonce[g];
                    m_lp_vld = 1'b1;
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (tkt[i]) begin
                    if (had[i] && g != i) m_ovf = 1'b1;
                    m_pend[i] = 1'b1;
                    m_nonce[i] = nonce_bus[32*i +: 32];
                end
            end
        end
    end

    // Monitor: half a cycle after each edge, compare the DUT against the model and scoreboard.
    always @(negedge clk) begin
        chk("tx_valid", {31'b0, gif.tx_valid}, {31'b0, (m_cnt > 0)});
        chk("tx_overflow", {31'b0, gif.tx_overflow}, {31'b0, m_ovf});
        if (gif.tx_valid && rdy && !reset) begin
            outputs++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", gif.tx_nonce, 32'hDEAD_BEEF);
            end else begin
                chk("tx_nonce", gif.tx_nonce, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        tkt  = '0;
        work = 1'b0;
    endtask

    task automatic fire(input int c, input logic [31:0] v);
        tkt[c] = 1'b1;
        nonce_bus[32*c +: 32] = v;
    endtask

    initial begin
        int n0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_valid", {31'b0, gif.tx_valid}, 32'd0);
        chk("reset_nonce", gif.tx_nonce, 32'd0);
        chk("reset_ovf", {31'b0, gif.tx_overflow}, 32'd0);

        // Single ticket latency.
        rdy = 1'b1;
        fire(0, 32'h1234_ABCD);
        tick();
        tick();
        chk("lat_valid", {31'b0, gif.tx_valid}, 32'd1);
        chk("lat_nonce", gif.tx_nonce, 32'h1234_ABCD);
        tick();
        chk("lat_valid_low", {31'b0, gif.tx_valid}, 32'd0);

        // Round-robin order after core 1 was last granted.
        fire(1, 32'h77);
        tick();
        tick();
        tick();
        fire(0, 32'hA);
        fire(1, 32'hB);
        tick();
        tick();
        chk("rr_first", gif.tx_nonce, 32'hA);
        tick();
        chk("rr_second", gif.tx_nonce, 32'hB);
        chk("rr_ovf", {31'b0, gif.tx_overflow}, 32'd0);
        tick();

        // Backpressure: four stored, fifth pending, sixth overwrites it.
        rdy = 1'b0;
        for (int j = 0; j < 6; j++) begin
            fire(0, 32'h100 + j);
            tick();
            tick();
        end
        chk("bp_ovf", {31'b0, gif.tx_overflow}, 32'd1);
        chk("bp_head", gif.tx_nonce, 32'h100);
        rdy = 1'b1;
        repeat (8) tick();

        // Work change flushes stored and pending tickets, keeps overflow.
        rdy = 1'b0;
        fire(0, 32'hC1); tick();
        fire(0, 32'hC2); tick();
        fire(0, 32'hC3); tick();
        tick();
        fire(1, 32'hC4); tick();
        work = 1'b1;
        fire(2, 32'hC5);
        tick();
        chk("wc_valid", {31'b0, gif.tx_valid}, 32'd0);
        chk("wc_ovf", {31'b0, gif.tx_overflow}, 32'd1);
        rdy = 1'b1;
        n0 = outputs;
        repeat (5) tick();
        chk("wc_no_output", outputs, n0);

        // Reset mid-stream with a full FIFO and overflow set.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rdy = 1'b0;
        for (int j = 0; j < 6; j++) begin
            fire(0, 32'hD0 + j);
            tick();
        end
        tick();
        chk("full_valid", {31'b0, gif.tx_valid}, 32'd1);
        chk("full_ovf", {31'b0, gif.tx_overflow}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_valid", {31'b0, gif.tx_valid}, 32'd0);
        chk("rst_nonce", gif.tx_nonce, 32'd0);
        chk("rst_ovf", {31'b0, gif.tx_overflow}, 32'd0);

`ifdef GOLDEN_NONCE_DEDUP_EN
        rdy = 1'b1;
        n0 = outputs;
        fire(1, 32'h55); repeat (3) tick();
        fire(1, 32'h55); repeat (3) tick();
        chk("dedup_one", outputs - n0, 32'd1);
        work = 1'b1;
        tick();
        fire(1, 32'h55); repeat (3) tick();
        chk("dedup_after_wc", outputs - n0, 32'd2);
`endif

        // Randomized traffic.
        for (int cyc = 0; cyc < 800; cyc++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            work  = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) fire(i, $urandom);
                    else fire(i, 32'($urandom_range(0, 3)));
                end
            end
            @(posedge clk);
            #2;
            tkt  = '0;
            work = 1'b0;
        end
        reset = 1'b0;
        rdy = 1'b1;
        repeat (20) tick();
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("drain_valid", {31'b0, gif.tx_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
